// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running pixel/line counters, raster decode,
// and a single output register that keeps sync pulses aligned with pixel colour.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] col,
    output logic [9:0] row,
    output logic       valid,
    input  logic [5:0] rgb_in,
    output logic [5:0] vga_rgb,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       hsync_raw;
    logic       vsync_raw;

    // Reset parks the counters on the last pixel of the frame so the first
    // edge after release lands on (0,0) without emitting a partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= H_LAST;
            v_cnt <= V_LAST;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
                v_cnt <= '0;
            end else begin
                v_cnt <= v_cnt + 10'd1;
            end
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    always_comb begin
        col        = h_cnt;
        row        = v_cnt;
        valid      = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        frame_tick = (h_cnt == '0) && (v_cnt == V_VIS);
        hsync_raw  = !((h_cnt >= HS_START) && (h_cnt < HS_END));
        vsync_raw  = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    end

    // Pins are registered together so colour and sync share the same one-clock lag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_rgb   <= '0;
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
        end else begin
            vga_rgb   <= valid ? rgb_in : 6'd0;
            vga_hsync <= hsync_raw;
            vga_vsync <= vsync_raw;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line/pixel timing and a
// shrunken-raster instance so frame, wrap and reset behaviour fit a short run.
module tb_vga_timing_gen;

    logic clk;
    logic rst_n_a, rst_n_b;

    logic [9:0] col_a, row_a, col_b, row_b;
    logic       valid_a, valid_b;
    logic [5:0] rgb_in_a, rgb_in_b, vga_rgb_a, vga_rgb_b;
    logic       hs_a, vs_a, tick_a, hs_b, vs_b, tick_b;

    int checks = 0;
    int errors = 0;

    // Small raster: 30 clocks/line (hsync low at h 20..25), 20 lines/frame
    // (vsync low at v 14..16), 600 clocks/frame, tick at (0,12).
    vga_timing_gen dut_a (
        .clk(clk), .rst_n(rst_n_a), .col(col_a), .row(row_a), .valid(valid_a),
        .rgb_in(rgb_in_a), .vga_rgb(vga_rgb_a), .vga_hsync(hs_a),
        .vga_vsync(vs_a), .frame_tick(tick_a)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
        .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(3), .V_BACK(3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n_b), .col(col_b), .row(row_b), .valid(valid_b),
        .rgb_in(rgb_in_b), .vga_rgb(vga_rgb_b), .vga_hsync(hs_b),
        .vga_vsync(vs_b), .frame_tick(tick_b)
    );

    // Screen-generator stand-ins.
    assign rgb_in_a = (col_a == 10'd5 && row_a == 10'd10) ? 6'b110000 :
                      (col_a >= 10'd640) ? 6'b111111 : 6'b001100;
    assign rgb_in_b = {col_b[2:0], row_b[2:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Counters for the free-running pass.
    int pos_err_a = 0, valid_err_a = 0, valid_line0 = 0, hs_low_line0 = 0, hs_low_a = 0;
    int vs_low_a = 0, tick_a_cnt = 0, row_jump_a = 0, rgb_err_a = 0;
    int hs_fall_col = -1, hs_fall_prev = -1, rgb_hit = -1, rgb_after = -1;
    int line_start[3] = '{-1, -1, -1};
    int pos_err_b = 0, valid_err_b = 0, rgb_err_b = 0, hs_low_b = 0, vs_low_b = 0;
    int tick_b_cnt = 0, tick_pos_err = 0, bad_interval = 0, last_tick = -1;
    int vs_fall_col = -1, vs_fall_row = -1, row_jump_b = 0;
    int wrap1_seen = 0, wrap1_err = 0, wrap0_seen = 0, wrap0_err = 0;

    initial begin
        int pca, pra, pcb, prb;
        logic pva, pvb, phs_a, pvs_b;
        logic [5:0] exp_rgb;
        int found, cnt, held_ticks;

        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        #1;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        #1;
        check("a_reset_col_async", col_a, 799);
        repeat (3) @(negedge clk);
        check("a_reset_col", col_a, 799);
        check("a_reset_row", row_a, 524);
        check("a_reset_valid", valid_a, 0);
        check("a_reset_hsync", hs_a, 1);
        check("a_reset_vsync", vs_a, 1);
        check("a_reset_rgb", vga_rgb_a, 0);
        check("a_reset_tick", tick_a, 0);
        check("b_reset_col", col_b, 29);
        check("b_reset_row", row_b, 19);

        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        pca = 799; pra = 524; pva = 1'b0; phs_a = 1'b1;
        pcb = 29;  prb = 19;  pvb = 1'b0; pvs_b = 1'b1;

        for (int i = 0; i < 9000; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("a_first_col", col_a, 0);
                check("a_first_row", row_a, 0);
                check("a_first_valid", valid_a, 1);
                check("a_first_rgb", vga_rgb_a, 0);
            end
            // ---- full-size instance ----
            if (int'(col_a) != i % 800 || int'(row_a) != (i / 800) % 525) pos_err_a++;
            if (valid_a != (col_a < 640 && row_a < 480)) valid_err_a++;
            if (i < 800 && valid_a) valid_line0++;
            if (col_a == 0 && row_a < 3) line_start[row_a] = i;
            if (i < 800 && !hs_a) hs_low_line0++;
            if (!hs_a) hs_low_a++;
            if (!hs_a && phs_a && hs_fall_col < 0) begin
                hs_fall_col = col_a;
                hs_fall_prev = pca;
            end
            if (!vs_a) vs_low_a++;
            if (tick_a) tick_a_cnt++;
            if (int'(row_a) != pra && col_a != 0) row_jump_a++;
            exp_rgb = !pva ? 6'd0 : (pca == 5 && pra == 10) ? 6'b110000 : 6'b001100;
            if (vga_rgb_a !== exp_rgb) rgb_err_a++;
            if (pca == 5 && pra == 10) rgb_hit = vga_rgb_a;
            if (pca == 6 && pra == 10) rgb_after = vga_rgb_a;
            pca = col_a; pra = row_a; pva = valid_a; phs_a = hs_a;

            // ---- small instance ----
            if (int'(col_b) != i % 30 || int'(row_b) != (i / 30) % 20) pos_err_b++;
            if (valid_b != (col_b < 16 && row_b < 12)) valid_err_b++;
            exp_rgb = pvb ? {3'(pcb), 3'(prb)} : 6'd0;
            if (vga_rgb_b !== exp_rgb) rgb_err_b++;
            if (!hs_b) hs_low_b++;
            if (!vs_b) vs_low_b++;
            if (!vs_b && pvs_b && vs_fall_col < 0) begin
                vs_fall_col = col_b;
                vs_fall_row = row_b;
            end
            if (int'(row_b) != prb && col_b != 0) row_jump_b++;
            if (tick_b) begin
                tick_b_cnt++;
                if (!(col_b == 0 && row_b == 12)) tick_pos_err++;
                if (last_tick >= 0 && i - last_tick != 600) bad_interval++;
                last_tick = i;
            end
            if (pcb == 29 && prb == 11) begin
                wrap1_seen++;
                if (!(col_b == 0 && row_b == 12 && tick_b)) wrap1_err++;
            end
            if (pcb == 29 && prb == 19) begin
                wrap0_seen++;
                if (!(col_b == 0 && row_b == 0)) wrap0_err++;
            end
            pcb = col_b; prb = row_b; pvb = valid_b; pvs_b = vs_b;
        end

        check("a_position", pos_err_a, 0);
        check("a_valid_decode", valid_err_a, 0);
        check("a_valid_per_line", valid_line0, 640);
        check("a_line0_len", line_start[1] - line_start[0], 800);
        check("a_line1_len", line_start[2] - line_start[1], 800);
        check("a_hsync_low_line0", hs_low_line0, 96);
        check("a_hsync_low_total", hs_low_a, 11 * 96);
        check("a_hsync_fall_col", hs_fall_col, 657);
        check("a_hsync_fall_prev", hs_fall_prev, 656);
        check("a_vsync_idle", vs_low_a, 0);
        check("a_no_tick", tick_a_cnt, 0);
        check("a_row_stable", row_jump_a, 0);
        check("a_rgb_pipeline", rgb_err_a, 0);
        check("a_rgb_hit", rgb_hit, 6'b110000);
        check("a_rgb_after", rgb_after, 6'b001100);

        check("b_position", pos_err_b, 0);
        check("b_valid_decode", valid_err_b, 0);
        check("b_rgb_pipeline", rgb_err_b, 0);
        check("b_hsync_low_total", hs_low_b, 300 * 6);
        check("b_vsync_low_total", vs_low_b, 15 * 90);
        check("b_vsync_fall_col", vs_fall_col, 1);
        check("b_vsync_fall_row", vs_fall_row, 14);
        check("b_row_stable", row_jump_b, 0);
        check("b_tick_count", tick_b_cnt, 15);
        check("b_tick_position", tick_pos_err, 0);
        check("b_tick_interval", bad_interval, 0);
        check("b_wrap_tick_seen", wrap1_seen, 15);
        check("b_wrap_tick", wrap1_err, 0);
        check("b_wrap_frame_seen", wrap0_seen, 15);
        check("b_wrap_frame", wrap0_err, 0);

        // Asynchronous reset dropped between edges in mid-frame.
        found = 0;
        for (int k = 0; k < 700 && found == 0; k++) begin
            @(negedge clk);
            if (col_b == 9 && row_b == 6) found = 1;
        end
        check("b_midframe_reached", found, 1);
        check("b_pre_reset_rgb", vga_rgb_b, 6'b000110);
        #2;
        rst_n_b = 1'b0;
        #1;
        check("b_async_col", col_b, 29);
        check("b_async_row", row_b, 19);
        check("b_async_valid", valid_b, 0);
        check("b_async_tick", tick_b, 0);
        check("b_async_rgb", vga_rgb_b, 0);
        check("b_async_hsync", hs_b, 1);
        check("b_async_vsync", vs_b, 1);

        held_ticks = 0;
        for (int k = 0; k < 1300; k++) begin
            @(negedge clk);
            if (tick_b || col_b != 29) held_ticks++;
        end
        check("b_held_reset_quiet", held_ticks, 0);

        rst_n_b = 1'b1;
        @(negedge clk);
        check("b_release_col", col_b, 0);
        check("b_release_row", row_b, 0);
        check("b_release_valid", valid_b, 1);
        check("b_release_tick", tick_b, 0);
        check("b_release_rgb", vga_rgb_b, 0);
        cnt = -1;
        for (int k = 1; k <= 700 && cnt < 0; k++) begin
            @(negedge clk);
            if (tick_b) cnt = k;
        end
        check("b_first_tick_delay", cnt, 360);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
